// File: rtl/draw_layer_arbiter.sv
// Fixed-priority pixel arbiter for object layers over the background, with per-frame
// player collision summaries. Optional collision pixel counter under DRAW_ARB_COLL_COUNT_EN.
module draw_layer_arbiter #(
    parameter int          NUM_LAYERS  = 4,
    parameter logic [7:0]  TRANSPARENT = 8'hFF,
    localparam int         IDX_W       = $clog2(NUM_LAYERS + 1)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic [NUM_LAYERS-1:0]     layerDrawReq,
    input  logic [8*NUM_LAYERS-1:0]   layerRGB,
    input  logic [7:0]                bgRGB,
    input  logic                      boardersDrawReq,
    output logic [7:0]                RGBout,
    output logic [IDX_W-1:0]          ownerIdx,
    output logic                      collisionPulse,
    output logic                      frameCollision,
    output logic                      frameBorderHit,
    output logic [15:0]               frameCollCount
);

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(NUM_LAYERS);

    logic [7:0]            layer_rgb [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] eff;

    // A layer only competes when it requests and is not painting the transparent key.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
            assign layer_rgb[gi] = layerRGB[8*gi +: 8];
            assign eff[gi]       = layerDrawReq[gi] && (layerRGB[8*gi +: 8] != TRANSPARENT);
        end
    endgenerate

    logic coll_hit;
    logic bord_hit;
    logic any_hit;

    assign coll_hit = eff[0] && (|eff[NUM_LAYERS-1:1]);
    assign bord_hit = eff[0] && boardersDrawReq;
    assign any_hit  = coll_hit || bord_hit;

    // Pixel path
    logic [7:0]       rgb_d,   rgb_q;
    logic [IDX_W-1:0] owner_d, owner_q;
    logic             pulse_d, pulse_q;

    always_comb begin
        rgb_d   = bgRGB;
        owner_d = BG_IDX;
        // Walk from lowest priority upward so the lowest index ends up winning.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                rgb_d   = layer_rgb[i];
                owner_d = IDX_W'(i);
            end
        end
        pulse_d = any_hit;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q   <= 8'h00;
            owner_q <= BG_IDX;
            pulse_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            owner_q <= owner_d;
            pulse_q <= pulse_d;
        end
    end

    // Frame summary FSM
    state_t state_d,      state_q;
    logic   coll_acc_d,   coll_acc_q;
    logic   bord_acc_d,   bord_acc_q;
    logic   frame_coll_d, frame_coll_q;
    logic   frame_bord_d, frame_bord_q;

    always_comb begin
        state_d      = state_q;
        coll_acc_d   = 1'b0;
        bord_acc_d   = 1'b0;
        frame_coll_d = frame_coll_q;
        frame_bord_d = frame_bord_q;
        case (state_q)
            WAIT_FRAME: begin
                frame_coll_d = 1'b0;
                frame_bord_d = 1'b0;
                // The arming pulse opens the first frame, so its own hits belong to it.
                if (startOfFrame) begin
                    state_d    = ACTIVE;
                    coll_acc_d = coll_hit;
                    bord_acc_d = bord_hit;
                end
            end
            ACTIVE: begin
                if (startOfFrame) begin
                    frame_coll_d = coll_acc_q;
                    frame_bord_d = bord_acc_q;
                    coll_acc_d   = coll_hit;
                    bord_acc_d   = bord_hit;
                end else begin
                    coll_acc_d   = coll_acc_q || coll_hit;
                    bord_acc_d   = bord_acc_q || bord_hit;
                end
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= WAIT_FRAME;
            coll_acc_q   <= 1'b0;
            bord_acc_q   <= 1'b0;
            frame_coll_q <= 1'b0;
            frame_bord_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            coll_acc_q   <= coll_acc_d;
            bord_acc_q   <= bord_acc_d;
            frame_coll_q <= frame_coll_d;
            frame_bord_q <= frame_bord_d;
        end
    end

`ifdef DRAW_ARB_COLL_COUNT_EN
    logic [15:0] coll_cnt_d,   coll_cnt_q;
    logic [15:0] frame_cnt_d,  frame_cnt_q;
    logic [15:0] hit_inc;

    assign hit_inc = any_hit ? 16'd1 : 16'd0;

    always_comb begin
        coll_cnt_d  = 16'd0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            WAIT_FRAME: begin
                frame_cnt_d = 16'd0;
                if (startOfFrame) begin
                    coll_cnt_d = hit_inc;
                end
            end
            ACTIVE: begin
                if (startOfFrame) begin
                    frame_cnt_d = coll_cnt_q;
                    coll_cnt_d  = hit_inc;
                end else if (any_hit && (coll_cnt_q != 16'hFFFF)) begin
                    coll_cnt_d  = coll_cnt_q + 16'd1;
                end else begin
                    coll_cnt_d  = coll_cnt_q;
                end
            end
            default: begin
                coll_cnt_d  = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            coll_cnt_q  <= 16'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            coll_cnt_q  <= coll_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frameCollCount = frame_cnt_q;
`else
    assign frameCollCount = 16'd0;
`endif

    assign RGBout         = rgb_q;
    assign ownerIdx       = owner_q;
    assign collisionPulse = pulse_q;
    assign frameCollision = frame_coll_q;
    assign frameBorderHit = frame_bord_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed bench for draw_layer_arbiter: pixel arbitration, overlap pulse and
// per-frame summaries, including mid-frame asynchronous reset.
module tb_draw_layer_arbiter;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [3:0]  layerDrawReq;
    logic [31:0] layerRGB;
    logic [7:0]  bgRGB;
    logic        boardersDrawReq;
    logic [7:0]  RGBout;
    logic [2:0]  ownerIdx;
    logic        collisionPulse;
    logic        frameCollision;
    logic        frameBorderHit;
    logic [15:0] frameCollCount;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef DRAW_ARB_COLL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    draw_layer_arbiter dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .layerDrawReq    (layerDrawReq),
        .layerRGB        (layerRGB),
        .bgRGB           (bgRGB),
        .boardersDrawReq (boardersDrawReq),
        .RGBout          (RGBout),
        .ownerIdx        (ownerIdx),
        .collisionPulse  (collisionPulse),
        .frameCollision  (frameCollision),
        .frameBorderHit  (frameBorderHit),
        .frameCollCount  (frameCollCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Apply one pixel's inputs (layers 3..0) then advance one clock.
    task automatic pix(input logic [3:0] req, input logic [7:0] l3, input logic [7:0] l2,
                       input logic [7:0] l1, input logic [7:0] l0,
                       input logic bord, input logic sof);
        layerDrawReq    = req;
        layerRGB        = {l3, l2, l1, l0};
        boardersDrawReq = bord;
        startOfFrame    = sof;
        @(posedge clk);
        #1;
        $display("pix req=%b rgb=%h sof=%b bord=%b -> RGBout=%h owner=%0d pulse=%b fc=%b fb=%b cnt=%0d",
                 req, {l3, l2, l1, l0}, sof, bord, RGBout, ownerIdx, collisionPulse,
                 frameCollision, frameBorderHit, frameCollCount);
    endtask

    task automatic idle(input logic sof);
        pix(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, sof);
    endtask

    task automatic overlap(input logic sof);
        pix(4'b1001, 8'h77, 8'h00, 8'h00, 8'h03, 1'b0, sof);
    endtask

    initial begin
        resetN          = 1'b0;
        startOfFrame    = 1'b0;
        layerDrawReq    = 4'b0000;
        layerRGB        = 32'hFFFF_FFFF;
        bgRGB           = 8'hE0;
        boardersDrawReq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb",   16'(RGBout), 16'h00);
        chk("rst_owner", 16'(ownerIdx), 16'd4);
        chk("rst_pulse", 16'(collisionPulse), 16'd0);
        chk("rst_fc",    16'(frameCollision), 16'd0);
        chk("rst_fb",    16'(frameBorderHit), 16'd0);
        chk("rst_cnt",   frameCollCount, 16'd0);
        resetN = 1'b1;

        // Pixel arbitration
        pix(4'b0100, 8'h00, 8'h1C, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("l2_rgb",   16'(RGBout), 16'h1C);
        chk("l2_owner", 16'(ownerIdx), 16'd2);
        chk("l2_pulse", 16'(collisionPulse), 16'd0);

        pix(4'b0011, 8'h00, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0);
        chk("transp_rgb",   16'(RGBout), 16'h5A);
        chk("transp_owner", 16'(ownerIdx), 16'd1);
        chk("transp_pulse", 16'(collisionPulse), 16'd0);

        overlap(1'b0);
        chk("ovl_rgb",   16'(RGBout), 16'h03);
        chk("ovl_owner", 16'(ownerIdx), 16'd0);
        chk("ovl_pulse", 16'(collisionPulse), 16'd1);

        idle(1'b0);
        chk("bg_rgb",   16'(RGBout), 16'hE0);
        chk("bg_owner", 16'(ownerIdx), 16'd4);
        chk("bg_pulse", 16'(collisionPulse), 16'd0);

        pix(4'b0001, 8'h00, 8'h00, 8'h00, 8'h10, 1'b1, 1'b0);
        chk("bord_pulse", 16'(collisionPulse), 16'd1);
        chk("wait_fc",    16'(frameCollision), 16'd0);

        // Street pixel alone with a border pulse is not a hit
        pix(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("street_pulse", 16'(collisionPulse), 16'd0);

        // Arm, three overlaps, publish
        idle(1'b1);
        chk("arm_fc", 16'(frameCollision), 16'd0);
        overlap(1'b0);
        overlap(1'b0);
        overlap(1'b0);
        idle(1'b1);
        chk("f1_fc",  16'(frameCollision), 16'd1);
        chk("f1_fb",  16'(frameBorderHit), 16'd0);
        chk("f1_cnt", frameCollCount, CNT_EN ? 16'd3 : 16'd0);
        idle(1'b0);
        idle(1'b0);
        chk("f1_hold_fc", 16'(frameCollision), 16'd1);
        idle(1'b1);
        chk("f2_fc",  16'(frameCollision), 16'd0);
        chk("f2_cnt", frameCollCount, 16'd0);

        // Border hit on the SOF cycle belongs to the new frame
        pix(4'b0001, 8'h00, 8'h00, 8'h00, 8'h10, 1'b1, 1'b1);
        chk("sofb_fb",    16'(frameBorderHit), 16'd0);
        chk("sofb_pulse", 16'(collisionPulse), 16'd1);
        idle(1'b0);
        idle(1'b1);
        chk("f4_fb",  16'(frameBorderHit), 16'd1);
        chk("f4_fc",  16'(frameCollision), 16'd0);
        chk("f4_cnt", frameCollCount, CNT_EN ? 16'd1 : 16'd0);

        // Back-to-back SOF pulses
        overlap(1'b1);
        chk("b2b1_fc", 16'(frameCollision), 16'd0);
        chk("b2b1_fb", 16'(frameBorderHit), 16'd0);
        idle(1'b1);
        chk("b2b2_fc",  16'(frameCollision), 16'd1);
        chk("b2b2_cnt", frameCollCount, CNT_EN ? 16'd1 : 16'd0);

        // Mid-frame asynchronous reset
        overlap(1'b0);
        overlap(1'b0);
        chk("pre_rst_pulse", 16'(collisionPulse), 16'd1);
        resetN = 1'b0;
        #1;
        $display("async reset -> RGBout=%h owner=%0d pulse=%b fc=%b fb=%b cnt=%0d",
                 RGBout, ownerIdx, collisionPulse, frameCollision, frameBorderHit, frameCollCount);
        chk("arst_fc",    16'(frameCollision), 16'd0);
        chk("arst_pulse", 16'(collisionPulse), 16'd0);
        chk("arst_rgb",   16'(RGBout), 16'h00);
        chk("arst_owner", 16'(ownerIdx), 16'd4);
        chk("arst_cnt",   frameCollCount, 16'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        idle(1'b1);
        chk("rearm_fc", 16'(frameCollision), 16'd0);
        overlap(1'b0);
        idle(1'b1);
        chk("post_fc",  16'(frameCollision), 16'd1);
        chk("post_cnt", frameCollCount, CNT_EN ? 16'd1 : 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
